// File: rtl/task_conflict_checker_if.sv
// Shared payload types and the FIFO-head / dispatch / finish bundle used by
// task_conflict_checker. The checker takes the slave modport; the FIFO and
// core-array side (or a bench) drives the master modport.

package task_conflict_checker_pkg;

  localparam int unsigned TTYPE_W = 8;
  localparam int unsigned OBJ_W   = 16;
  localparam int unsigned ARG_W   = 32;
  localparam int unsigned SLICE_W = 4;
  localparam int unsigned SLOT_W  = 6;

  // Task descriptor; object is the conflict key.
  typedef struct packed {
    logic [TTYPE_W-1:0] ttype;
    logic [OBJ_W-1:0]   object;
    logic [ARG_W-1:0]   arg;
  } task_t;

  // Location of the task inside the commit-queue slice.
  typedef struct packed {
    logic [SLICE_W-1:0] slice;
    logic [SLOT_W-1:0]  slot;
  } cq_slice_slot_t;

endpackage

interface task_conflict_checker_if #(
  parameter int unsigned CID_W = 2
);
  import task_conflict_checker_pkg::*;

  logic             s_rvalid;
  task_t            s_rdata;
  cq_slice_slot_t   s_rslot;
  logic             s_rresp;
  logic             s_rresp_valid;

  logic             m_valid;
  logic             m_ready;
  task_t            m_task;
  cq_slice_slot_t   m_slot;
  logic [CID_W-1:0] m_cid;

  logic             fin_valid;
  logic [CID_W-1:0] fin_cid;

  modport master (
    output s_rvalid, s_rdata, s_rslot, m_ready, fin_valid, fin_cid,
    input  s_rresp, s_rresp_valid, m_valid, m_task, m_slot, m_cid
  );

  modport slave (
    input  s_rvalid, s_rdata, s_rslot, m_ready, fin_valid, fin_cid,
    output s_rresp, s_rresp_valid, m_valid, m_task, m_slot, m_cid
  );

endinterface

// File: rtl/task_conflict_checker.sv
// Task conflict checker: takes the head of a task-type FIFO, rejects it if its
// object is held by a running core (or no core is free), otherwise dispatches
// it to the lowest free core and accepts it.
// Optional feature macro: CONFLICT_STATS_EN adds saturating accept/reject
// counters on n_accept/n_reject; without it both ports are tied to zero.

module task_conflict_checker
  import task_conflict_checker_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned CID_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  task_conflict_checker_if.slave  bus,
  output logic                    busy,
  output logic [31:0]             n_accept,
  output logic [31:0]             n_reject
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPATCH
  } state_e;

  state_e             state;
  task_t              hold_task;
  cq_slice_slot_t     hold_slot;

  logic [N_CORES-1:0] act_valid;
  logic [OBJ_W-1:0]   act_obj [N_CORES];

  logic [N_CORES-1:0] fin_hit_c;
  logic               conflict_c;
  logic               free_found_c;
  logic [CID_W-1:0]   free_cid_c;
  logic               dispatch_done_c;

  // Finish decode, object conflict search and lowest-free-core pick.
  always_comb begin
    fin_hit_c    = '0;
    conflict_c   = 1'b0;
    free_found_c = 1'b0;
    free_cid_c   = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      fin_hit_c[i] = bus.fin_valid && (bus.fin_cid == CID_W'(i));
    end
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (act_valid[i] && (act_obj[i] == hold_task.object) && !fin_hit_c[i]) begin
        conflict_c = 1'b1;
      end
      if (!free_found_c && (!act_valid[i] || fin_hit_c[i])) begin
        free_found_c = 1'b1;
        free_cid_c   = CID_W'(i);
      end
    end
  end

  assign dispatch_done_c = (state == ST_DISPATCH) && bus.m_ready;

  // Control FSM: sample head, check, dispatch, respond.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state             <= ST_IDLE;
      hold_task         <= '0;
      hold_slot         <= '0;
      bus.s_rresp       <= 1'b0;
      bus.s_rresp_valid <= 1'b0;
      bus.m_valid       <= 1'b0;
      bus.m_task        <= '0;
      bus.m_slot        <= '0;
      bus.m_cid         <= '0;
    end else begin
      bus.s_rresp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The FIFO head moves on the response edge, so skip that cycle.
          if (bus.s_rvalid && !bus.s_rresp_valid) begin
            hold_task <= bus.s_rdata;
            hold_slot <= bus.s_rslot;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (conflict_c || !free_found_c) begin
            bus.s_rresp_valid <= 1'b1;
            bus.s_rresp       <= 1'b1;
            state             <= ST_IDLE;
          end else begin
            bus.m_valid <= 1'b1;
            bus.m_cid   <= free_cid_c;
            bus.m_task  <= hold_task;
            bus.m_slot  <= hold_slot;
            state       <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (bus.m_ready) begin
            bus.m_valid       <= 1'b0;
            bus.s_rresp_valid <= 1'b1;
            bus.s_rresp       <= 1'b0;
            state             <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Active-object table valid bits: finish clears, dispatch completion sets (set wins).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      act_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CORES; i++) begin
        if (dispatch_done_c && (bus.m_cid == CID_W'(i))) begin
          act_valid[i] <= 1'b1;
        end else if (fin_hit_c[i]) begin
          act_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Active-object table keys; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (dispatch_done_c && (bus.m_cid == CID_W'(i))) begin
        act_obj[i] <= hold_task.object;
      end
    end
  end

  assign busy = (state != ST_IDLE) || (|act_valid);

`ifdef CONFLICT_STATS_EN
  // Saturating accept/reject counters, one step per response pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_accept <= '0;
      n_reject <= '0;
    end else if (bus.s_rresp_valid) begin
      if (bus.s_rresp) begin
        if (n_reject != 32'hFFFF_FFFF) n_reject <= n_reject + 32'd1;
      end else begin
        if (n_accept != 32'hFFFF_FFFF) n_accept <= n_accept + 32'd1;
      end
    end
  end
`else
  assign n_accept = '0;
  assign n_reject = '0;
`endif

endmodule

// File: tb/tb_task_conflict_checker.sv
// Self-checking bench for task_conflict_checker against a table-of-cores model.

module tb_task_conflict_checker;
  import task_conflict_checker_pkg::*;

  localparam int unsigned N_CORES = 4;
  localparam int unsigned CID_W   = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        busy;
  logic [31:0] n_accept;
  logic [31:0] n_reject;

  task_conflict_checker_if #(.CID_W(CID_W)) bus ();

  task_conflict_checker #(.N_CORES(N_CORES), .CID_W(CID_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .busy     (busy),
    .n_accept (n_accept),
    .n_reject (n_reject)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which cores are running and on which object.
  bit          mv [N_CORES];
  logic [15:0] mo [N_CORES];
  int          exp_acc;
  int          exp_rej;

  function automatic bit model_any();
    bit a = 1'b0;
    for (int i = 0; i < N_CORES; i++) a |= mv[i];
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CORES; i++) mv[i] = 1'b0;
    exp_acc = 0;
    exp_rej = 0;
  endtask

  task automatic idle_inputs();
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    bus.s_rslot   = '0;
    bus.m_ready   = 1'b0;
    bus.fin_valid = 1'b0;
    bus.fin_cid   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    model_reset();
  endtask

  // One FIFO head through sample/check/dispatch/response, checked against the model.
  task automatic run_head(input string tag, input logic [15:0] obj, input int delay,
                          input bit fin_en, input int fin_id,
                          output bit accepted, output int cid);
    task_t          t;
    cq_slice_slot_t s;
    bit             conflict;
    int             free;
    bit             hit;
    t = '{ttype: 8'($urandom), object: obj, arg: 32'($urandom)};
    s = cq_slice_slot_t'(10'($urandom));
    bus.s_rdata  = t;
    bus.s_rslot  = s;
    bus.s_rvalid = 1'b1;
    tick();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_rresp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s sample: m_valid=%0b rresp_valid=%0b busy=%0b, required 0 0 1",
               tag, bus.m_valid, bus.s_rresp_valid, busy);
    end
    // Head goes away and the bus carries junk; the held copy must be used.
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = task_t'(56'({$urandom, $urandom}));
    bus.s_rslot   = cq_slice_slot_t'(10'($urandom));
    bus.fin_valid = fin_en;
    bus.fin_cid   = CID_W'(fin_id);
    bus.m_ready   = (delay == 0);
    conflict = 1'b0;
    free     = -1;
    for (int i = 0; i < N_CORES; i++) begin
      hit = fin_en && (fin_id == i);
      if (mv[i] && mo[i] == obj && !hit) conflict = 1'b1;
      if (free < 0 && (!mv[i] || hit)) free = i;
    end
    for (int i = 0; i < N_CORES; i++) if (fin_en && fin_id == i) mv[i] = 1'b0;
    tick();
    bus.fin_valid = 1'b0;
    if (conflict || free < 0) begin
      accepted = 1'b0;
      cid      = -1;
      exp_rej++;
      checks++;
      if (bus.s_rresp_valid !== 1'b1 || bus.s_rresp !== 1'b1 || bus.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s reject: rresp_valid=%0b rresp=%0b m_valid=%0b, required 1 1 0",
                 tag, bus.s_rresp_valid, bus.s_rresp, bus.m_valid);
      end
    end else begin
      accepted = 1'b1;
      cid      = free;
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_cid !== CID_W'(free) || bus.m_task !== t ||
          bus.m_slot !== s || bus.s_rresp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s dispatch: m_valid=%0b m_cid=%0d task=%h slot=%h rv=%0b, required 1 %0d %h %h 0",
                 tag, bus.m_valid, bus.m_cid, bus.m_task, bus.m_slot, bus.s_rresp_valid, free, t, s);
      end
      for (int k = 0; k < delay; k++) begin
        tick();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_cid !== CID_W'(free) || bus.m_task !== t ||
            bus.m_slot !== s || bus.s_rresp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s stall%0d: m_valid=%0b m_cid=%0d task=%h rv=%0b, required 1 %0d %h 0",
                   tag, k, bus.m_valid, bus.m_cid, bus.m_task, bus.s_rresp_valid, free, t);
        end
      end
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      mv[free] = 1'b1;
      mo[free] = obj;
      exp_acc++;
      checks++;
      if (bus.s_rresp_valid !== 1'b1 || bus.s_rresp !== 1'b0 || bus.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s accept: rresp_valid=%0b rresp=%0b m_valid=%0b, required 1 0 0",
                 tag, bus.s_rresp_valid, bus.s_rresp, bus.m_valid);
      end
    end
    tick();
    checks++;
    if (bus.s_rresp_valid !== 1'b0 || busy !== model_any()) begin
      errors++;
      $display("FAIL %s after: rresp_valid=%0b busy=%0b, required 0 %0b",
               tag, bus.s_rresp_valid, busy, model_any());
    end
  endtask

  task automatic finish_core(input string tag, input int id);
    bus.fin_valid = 1'b1;
    bus.fin_cid   = CID_W'(id);
    tick();
    bus.fin_valid = 1'b0;
    mv[id] = 1'b0;
    checks++;
    if (busy !== model_any()) begin
      errors++;
      $display("FAIL %s finish%0d: busy=%0b, required %0b", tag, id, busy, model_any());
    end
  endtask

  task automatic check_stats(input string tag);
    checks++;
`ifdef CONFLICT_STATS_EN
    if (n_accept !== 32'(exp_acc) || n_reject !== 32'(exp_rej)) begin
      errors++;
      $display("FAIL %s stats: n_accept=%0d n_reject=%0d, required %0d %0d",
               tag, n_accept, n_reject, exp_acc, exp_rej);
    end
`else
    if (n_accept !== 32'd0 || n_reject !== 32'd0) begin
      errors++;
      $display("FAIL %s stats: n_accept=%0d n_reject=%0d, required 0 0", tag, n_accept, n_reject);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.s_rresp_valid !== 1'b0 || bus.s_rresp !== 1'b0 || bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rv=%0b rresp=%0b m_valid=%0b busy=%0b, required 0 0 0 0",
               bus.s_rresp_valid, bus.s_rresp, bus.m_valid, busy);
    end
    check_stats("reset");
  endtask

  task automatic test_accept_and_conflict();
    bit a; int c;
    do_reset();
    run_head("first_accept", 16'h0010, 0, 1'b0, 0, a, c);
    run_head("same_obj_reject", 16'h0010, 0, 1'b0, 0, a, c);
    run_head("other_obj_accept", 16'h0011, 1, 1'b0, 0, a, c);
  endtask

  task automatic test_all_busy();
    bit a; int c;
    do_reset();
    run_head("fill0", 16'h0011, 0, 1'b0, 0, a, c);
    run_head("fill1", 16'h0012, 0, 1'b0, 0, a, c);
    run_head("fill2", 16'h0013, 0, 1'b0, 0, a, c);
    run_head("fill3", 16'h0014, 0, 1'b0, 0, a, c);
    run_head("full_reject", 16'h0099, 0, 1'b0, 0, a, c);
    run_head("fin_in_check", 16'h0099, 0, 1'b1, 2, a, c);
  endtask

  task automatic test_fin_same_cycle();
    bit a; int c;
    do_reset();
    run_head("pre0", 16'h0005, 0, 1'b0, 0, a, c);
    run_head("pre1", 16'h0020, 0, 1'b0, 0, a, c);
    finish_core("free0", 0);
    run_head("fin_clears_conflict", 16'h0020, 0, 1'b1, 1, a, c);
    finish_core("fin_invalid", 3);
  endtask

  task automatic test_backpressure();
    bit a; int c;
    do_reset();
    run_head("stall5", 16'h0033, 5, 1'b0, 0, a, c);
  endtask

  // Head held valid through the response cycle must not be re-sampled there.
  task automatic test_back_to_back();
    bit a; int c;
    do_reset();
    run_head("b2b_setup", 16'h0044, 0, 1'b0, 0, a, c);
    bus.s_rdata  = '{ttype: 8'h1, object: 16'h0044, arg: 32'h0};
    bus.s_rslot  = '0;
    bus.s_rvalid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.s_rresp_valid !== 1'b1 || bus.s_rresp !== 1'b1) begin
      errors++;
      $display("FAIL b2b first: rv=%0b rresp=%0b, required 1 1", bus.s_rresp_valid, bus.s_rresp);
    end
    tick();
    checks++;
    if (bus.s_rresp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b gap1: rv=%0b, required 0", bus.s_rresp_valid);
    end
    tick();
    checks++;
    if (bus.s_rresp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b gap2: rv=%0b, required 0", bus.s_rresp_valid);
    end
    bus.s_rvalid = 1'b0;
    tick();
    exp_rej += 2;
    checks++;
    if (bus.s_rresp_valid !== 1'b1 || bus.s_rresp !== 1'b1) begin
      errors++;
      $display("FAIL b2b second: rv=%0b rresp=%0b, required 1 1", bus.s_rresp_valid, bus.s_rresp);
    end
    tick();
  endtask

  task automatic test_stats();
    bit a; int c;
    do_reset();
    run_head("st_a1", 16'h0001, 0, 1'b0, 0, a, c);
    run_head("st_a2", 16'h0002, 0, 1'b0, 0, a, c);
    run_head("st_r1", 16'h0001, 0, 1'b0, 0, a, c);
    run_head("st_a3", 16'h0003, 0, 1'b0, 0, a, c);
    run_head("st_r2", 16'h0002, 0, 1'b0, 0, a, c);
    check_stats("stats_3_2");
  endtask

  task automatic test_reset_mid_dispatch();
    bit a; int c;
    bus.s_rdata  = '{ttype: 8'h2, object: 16'h0077, arg: 32'h5};
    bus.s_rslot  = '0;
    bus.s_rvalid = 1'b1;
    bus.m_ready  = 1'b0;
    tick();
    bus.s_rvalid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    model_reset();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_rresp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst: m_valid=%0b rv=%0b busy=%0b, required 0 0 0",
               bus.m_valid, bus.s_rresp_valid, busy);
    end
    check_stats("midrst");
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.s_rresp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst pulse: rv=%0b, required 0", bus.s_rresp_valid);
    end
    run_head("after_midrst", 16'h0077, 0, 1'b0, 0, a, c);
  endtask

  task automatic test_random();
    bit a; int c;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        finish_core("rnd_fin", int'($urandom_range(0, N_CORES - 1)));
      end else begin
        run_head("rnd", 16'h0040 + 16'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, N_CORES - 1)), a, c);
      end
    end
    check_stats("rnd_stats");
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_accept_and_conflict();
    test_all_busy();
    test_fin_same_cycle();
    test_backpressure();
    test_back_to_back();
    test_stats();
    test_reset_mid_dispatch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
